// File: rtl/req_encode8_3.sv
// ---------------------------------------------------------------------------
// req_encode8_3
//
// Registered 8-to-3 request encoder. It is the inverse of the RAM bank 3-to-8
// select decoder. Sticky request lines are collected into a pending register.
// One encoded index at a time is offered to a consumer over a valid/ready
// handshake, and the accepted line is cleared from the pending register.
//
// Configuration macro:
//   ROUND_ROBIN_EN  When defined, indices are selected round-robin. The scan
//                   starts one above the last accepted index and wraps.
//                   When undefined, selection is fixed priority and the
//                   highest index wins; no pointer register is built.
//
// Ports:
//   clk    in   1      clock; all state changes on the rising edge
//   rst    in   1      synchronous active-high reset, highest priority
//   En     in   1      capture enable; Req is ignored while low
//   Req    in   N_REQ  request lines, level-sampled each cycle while En=1
//   Ready  in   1      consumer accepts Z this cycle when Valid=1
//   Z      out  IDX_W  encoded index of the presented request (registered)
//   Valid  out  1      Z holds a pending request (registered)
//   Pend   out  N_REQ  pending-request register (registered)
//   Ovf    out  1      one-cycle pulse: a request hit an already-pending line
// ---------------------------------------------------------------------------
module req_encode8_3 #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [N_REQ-1:0] Req,
    input  logic             Ready,
    output logic [IDX_W-1:0] Z,
    output logic             Valid,
    output logic [N_REQ-1:0] Pend,
    output logic             Ovf
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] p_q, p_d;
    logic [IDX_W-1:0] z_q, z_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

    logic             acc_s;
    logic [N_REQ-1:0] clr_s;
    logic [N_REQ-1:0] set_s;
    logic [N_REQ-1:0] rem_s;
    logic [IDX_W-1:0] sel_p_s;
    logic [IDX_W-1:0] sel_r_s;

    // One-hot expansion of an index.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef ROUND_ROBIN_EN
    // First set bit scanning upward from start+1, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] sel_rr(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] s;
        logic [IDX_W-1:0] cand;
        logic             found;
        s     = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = start + IDX_W'(k);
            if (!found && v[cand]) begin
                s     = cand;
                found = 1'b1;
            end else begin
                s     = s;
            end
        end
        return s;
    endfunction
`else
    // Highest set index; later (higher) hits overwrite earlier ones.
    function automatic logic [IDX_W-1:0] sel_hi(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] s;
        s = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                s = IDX_W'(i);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction
`endif

    // Handshake, clear/set masks and candidate selections shared by both comb processes.
    always_comb begin
        acc_s = valid_q & Ready;
        if (acc_s) begin
            clr_s = onehot(z_q);
        end else begin
            clr_s = {N_REQ{1'b0}};
        end
        set_s = Req & {N_REQ{En}};
        // Remaining work after the current index leaves; this cycle's set is excluded
        // so a re-requested line is presented again later rather than immediately.
        rem_s = p_q & ~onehot(z_q);
`ifdef ROUND_ROBIN_EN
        sel_p_s = sel_rr(p_q, ptr_q);
        sel_r_s = sel_rr(rem_s, ptr_q);
`else
        sel_p_s = sel_hi(p_q);
        sel_r_s = sel_hi(rem_s);
`endif
    end

    // State register plus all datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= {N_REQ{1'b0}};
            z_q     <= {IDX_W{1'b0}};
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (p_q != {N_REQ{1'b0}}) begin
                    state_d = ST_PRESENT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (acc_s && (rem_s == {N_REQ{1'b0}})) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        // Set wins over clear on the same bit.
        p_d     = (p_q & ~clr_s) | set_s;
        ovf_d   = |(set_s & p_q & ~clr_s);
        z_d     = z_q;
        valid_d = valid_q;
`ifdef ROUND_ROBIN_EN
        if (acc_s) begin
            ptr_d = z_q;
        end else begin
            ptr_d = ptr_q;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (p_q != {N_REQ{1'b0}}) begin
                    z_d     = sel_p_s;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_PRESENT: begin
                // Z and Valid only move on an accept.
                if (acc_s) begin
                    if (rem_s != {N_REQ{1'b0}}) begin
                        z_d     = sel_r_s;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign Z     = z_q;
    assign Valid = valid_q;
    assign Pend  = p_q;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_req_encode8_3.sv
// ---------------------------------------------------------------------------
// tb_req_encode8_3
//
// Directed self-checking bench for req_encode8_3. Inputs change 1 time unit
// after a rising edge, and outputs are sampled at that same point. Expected
// values are hand-computed for each vector.
// ---------------------------------------------------------------------------
module tb_req_encode8_3;

    logic       clk;
    logic       rst;
    logic       En;
    logic [7:0] Req;
    logic       Ready;
    logic [2:0] Z;
    logic       Valid;
    logic [7:0] Pend;
    logic       Ovf;

    int n_total;
    int n_bad;

    req_encode8_3 dut (
        .clk   (clk),
        .rst   (rst),
        .En    (En),
        .Req   (Req),
        .Ready (Ready),
        .Z     (Z),
        .Valid (Valid),
        .Pend  (Pend),
        .Ovf   (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_z;
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        En      = 1'b0;
        Req     = 8'h00;
        Ready   = 1'b0;

        // ---- 1: reset state, then two requests drained back to back
        step();
        rst = 1'b0;
        check_eq("rst_pend",  {24'd0, Pend}, 32'h0);
        check_eq("rst_valid", {31'd0, Valid}, 32'd0);
        check_eq("rst_z",     {29'd0, Z}, 32'd0);
        check_eq("rst_ovf",   {31'd0, Ovf}, 32'd0);
        Req = 8'h24; En = 1'b1; Ready = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        check_eq("t1_pend",   {24'd0, Pend}, 32'h24);
        check_eq("t1_nvalid", {31'd0, Valid}, 32'd0);
        step();
        check_eq("t1_valid",  {31'd0, Valid}, 32'd1);
`ifdef ROUND_ROBIN_EN
        check_eq("t1_z0",     {29'd0, Z}, 32'd2);
`else
        check_eq("t1_z0",     {29'd0, Z}, 32'd5);
`endif
        step();
        check_eq("t1_valid1", {31'd0, Valid}, 32'd1);
`ifdef ROUND_ROBIN_EN
        check_eq("t1_z1",     {29'd0, Z}, 32'd5);
        check_eq("t1_pend1",  {24'd0, Pend}, 32'h20);
`else
        check_eq("t1_z1",     {29'd0, Z}, 32'd2);
        check_eq("t1_pend1",  {24'd0, Pend}, 32'h04);
`endif
        step();
        check_eq("t1_done_v", {31'd0, Valid}, 32'd0);
        check_eq("t1_done_p", {24'd0, Pend}, 32'h0);

        // ---- 2: requests ignored while En=0
        En = 1'b0; Req = 8'hFF; Ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_eq("t2_pend",  {24'd0, Pend}, 32'h0);
            check_eq("t2_valid", {31'd0, Valid}, 32'd0);
            check_eq("t2_ovf",   {31'd0, Ovf}, 32'd0);
        end
        Req = 8'h00;

        // ---- 3: Z held while Ready=0, a new request never disturbs it
        Ready = 1'b0; Req = 8'h04; En = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        step();
        check_eq("t3_z",     {29'd0, Z}, 32'd2);
        check_eq("t3_valid", {31'd0, Valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                Req = 8'h80; En = 1'b1;
            end else begin
                Req = 8'h00; En = 1'b0;
            end
            step();
            check_eq("t3_hold_z", {29'd0, Z}, 32'd2);
            check_eq("t3_hold_v", {31'd0, Valid}, 32'd1);
        end
        Req = 8'h00; En = 1'b0;
        check_eq("t3_pend", {24'd0, Pend}, 32'h84);
        Ready = 1'b1;
        step();
        check_eq("t3_next_z", {29'd0, Z}, 32'd7);
        check_eq("t3_next_v", {31'd0, Valid}, 32'd1);
        step();
        check_eq("t3_done_v", {31'd0, Valid}, 32'd0);
        check_eq("t3_done_p", {24'd0, Pend}, 32'h0);

        // ---- 4: re-request on accept stays pending without Ovf; re-request while pending pulses Ovf
        Ready = 1'b0; Req = 8'h08; En = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        step();
        check_eq("t4_z", {29'd0, Z}, 32'd3);
        Ready = 1'b1; Req = 8'h08; En = 1'b1;
        step();
        Ready = 1'b0; Req = 8'h00; En = 1'b0;
        check_eq("t4_pend3",  {24'd0, Pend}, 32'h08);
        check_eq("t4_noovf",  {31'd0, Ovf}, 32'd0);
        check_eq("t4_gap_v",  {31'd0, Valid}, 32'd0);
        step();
        check_eq("t4_rez",    {29'd0, Z}, 32'd3);
        check_eq("t4_rev",    {31'd0, Valid}, 32'd1);
        Req = 8'h08; En = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        check_eq("t4_ovf",    {31'd0, Ovf}, 32'd1);
        step();
        check_eq("t4_ovf_off", {31'd0, Ovf}, 32'd0);
        Ready = 1'b1;
        step();
        check_eq("t4_done_p", {24'd0, Pend}, 32'h0);
        check_eq("t4_done_v", {31'd0, Valid}, 32'd0);

        // ---- 5: reset mid-handshake
        Ready = 1'b0; Req = 8'h81; En = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        step();
        check_eq("t5_pre_p", {24'd0, Pend}, 32'h81);
        check_eq("t5_pre_v", {31'd0, Valid}, 32'd1);
        rst = 1'b1; Ready = 1'b1;
        step();
        rst = 1'b0; Ready = 1'b0;
        check_eq("t5_v",   {31'd0, Valid}, 32'd0);
        check_eq("t5_z",   {29'd0, Z}, 32'd0);
        check_eq("t5_p",   {24'd0, Pend}, 32'h0);
        check_eq("t5_ovf", {31'd0, Ovf}, 32'd0);
        Req = 8'h10; En = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        step();
        check_eq("t5_after_z", {29'd0, Z}, 32'd4);
        check_eq("t5_after_v", {31'd0, Valid}, 32'd1);
        Ready = 1'b1;
        step();
        check_eq("t5_after_done", {31'd0, Valid}, 32'd0);

        // ---- 6: all eight lines at once, drained one per cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        Ready = 1'b1; Req = 8'hFF; En = 1'b1;
        step();
        Req = 8'h00; En = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_z = 3'(i);
`else
            exp_z = 3'(7 - i);
`endif
            check_eq("t6_v", {31'd0, Valid}, 32'd1);
            check_eq("t6_z", {29'd0, Z}, {29'd0, exp_z});
            step();
        end
        check_eq("t6_done_v", {31'd0, Valid}, 32'd0);
        check_eq("t6_done_p", {24'd0, Pend}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
